// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: one slave port shared by NUM_M masters,
// whole CYC tenures granted, LOCK honoured, hung transfers ended by a watchdog ERR.
module wb_rr_arbiter #(
  parameter int NUM_M     = 4,
  parameter int WB_ADDR_W = 32,
  parameter int WB_DATA_W = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                           CLK_I,
  input  logic                           RST_I,
  input  logic [NUM_M-1:0]               m_cyc_i,
  input  logic [NUM_M-1:0]               m_stb_i,
  input  logic [NUM_M-1:0]               m_we_i,
  input  logic [NUM_M-1:0]               m_lock_i,
  input  logic [NUM_M*WB_ADDR_W-1:0]     m_adr_i,
  input  logic [NUM_M*WB_DATA_W-1:0]     m_dat_i,
  input  logic [NUM_M*(WB_DATA_W/8)-1:0] m_sel_i,
  input  logic [NUM_M*3-1:0]             m_cti_i,
  input  logic [NUM_M*2-1:0]             m_bte_i,
  output logic [NUM_M-1:0]               m_ack_o,
  output logic [NUM_M-1:0]               m_err_o,
  output logic [NUM_M-1:0]               m_rty_o,
  output logic [WB_DATA_W-1:0]           m_dat_o,
  output logic                           CYC_O,
  output logic                           STB_O,
  output logic                           WE_O,
  output logic                           LOCK_O,
  output logic [WB_ADDR_W-1:0]           ADR_O,
  output logic [WB_DATA_W-1:0]           DAT_O,
  output logic [WB_DATA_W/8-1:0]         SEL_O,
  output logic [2:0]                     CTI_O,
  output logic [1:0]                     BTE_O,
  input  logic [WB_DATA_W-1:0]           DAT_I,
  input  logic                           ACK_I,
  input  logic                           ERR_I,
  input  logic                           RTY_I,
  output logic [NUM_M-1:0]               grant_o,
  output logic                           timeout_o
);

  localparam int SEL_W = WB_DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_M);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] owner;
  logic [NUM_M-1:0] grant_q;
  logic [WD_W-1:0]  wd_cnt;

  logic [IDX_W-1:0] pick;
  logic [IDX_W:0]   idx;
  logic             found;
  logic             stb_raw;
  logic             slave_resp;
  logic             expire;
  logic             slave_stb;

  // First requester after the last owner, wrapping around the master list.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = {1'b0, last} + (IDX_W + 1)'(i);
      if (idx >= (IDX_W + 1)'(NUM_M)) idx = idx - (IDX_W + 1)'(NUM_M);
      if (!found && m_cyc_i[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign stb_raw    = (state == ST_OWN) && m_cyc_i[owner] && m_stb_i[owner];
  assign slave_resp = ACK_I | ERR_I | RTY_I;
  // A slave response in the expiry cycle wins over the watchdog.
  assign expire     = (TIMEOUT > 0) && stb_raw && !slave_resp && (wd_cnt == WD_LIMIT);
  assign slave_stb  = stb_raw && !expire;

  assign timeout_o = expire;
  assign grant_o   = grant_q;
  assign m_dat_o   = DAT_I;

  always_comb begin
    CYC_O   = 1'b0;
    STB_O   = 1'b0;
    WE_O    = 1'b0;
    LOCK_O  = 1'b0;
    ADR_O   = '0;
    DAT_O   = '0;
    SEL_O   = '0;
    CTI_O   = '0;
    BTE_O   = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state == ST_OWN) begin
      CYC_O          = m_cyc_i[owner];
      STB_O          = slave_stb;
      WE_O           = m_we_i[owner];
      LOCK_O         = m_lock_i[owner];
      ADR_O          = m_adr_i[owner*WB_ADDR_W +: WB_ADDR_W];
      DAT_O          = m_dat_i[owner*WB_DATA_W +: WB_DATA_W];
      SEL_O          = m_sel_i[owner*SEL_W +: SEL_W];
      CTI_O          = m_cti_i[owner*3 +: 3];
      BTE_O          = m_bte_i[owner*2 +: 2];
      m_ack_o[owner] = ACK_I & slave_stb;
      m_err_o[owner] = (ERR_I & slave_stb) | expire;
      m_rty_o[owner] = RTY_I & slave_stb;
    end
  end

  // Tenure control: a grant lasts until the owner has dropped both CYC and LOCK.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      last    <= IDX_W'(NUM_M - 1);
      owner   <= '0;
    end else if (state == ST_IDLE) begin
      if (|m_cyc_i) begin
        state   <= ST_OWN;
        owner   <= pick;
        grant_q <= NUM_M'(1) << pick;
      end
    end else begin
      if (!m_cyc_i[owner] && !m_lock_i[owner]) begin
        state   <= ST_IDLE;
        last    <= owner;
        grant_q <= '0;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wd_cnt <= '0;
    end else if ((TIMEOUT == 0) || !stb_raw || slave_resp || expire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed vector table, hand-written
// corner sequences and a randomized phase against a tenure-level reference model.
module tb_wb_rr_arbiter;

  localparam int NUM_M   = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic                CLK_I = 1'b0;
  logic                RST_I;
  logic [NUM_M-1:0]    m_cyc_i, m_stb_i, m_we_i, m_lock_i;
  logic [NUM_M*AW-1:0] m_adr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [NUM_M*4-1:0]  m_sel_i;
  logic [NUM_M*3-1:0]  m_cti_i;
  logic [NUM_M*2-1:0]  m_bte_i;
  logic [NUM_M-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [DW-1:0]       m_dat_o;
  logic                CYC_O, STB_O, WE_O, LOCK_O;
  logic [AW-1:0]       ADR_O;
  logic [DW-1:0]       DAT_O;
  logic [3:0]          SEL_O;
  logic [2:0]          CTI_O;
  logic [1:0]          BTE_O;
  logic [DW-1:0]       DAT_I;
  logic                ACK_I, ERR_I, RTY_I;
  logic [NUM_M-1:0]    grant_o;
  logic                timeout_o;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model: owner index (-1 = bus free), last owner, stalled-strobe count.
  int mdl_owner;
  int mdl_last;
  int mdl_cnt;

  wb_rr_arbiter #(
    .NUM_M(NUM_M), .WB_ADDR_W(AW), .WB_DATA_W(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_lock_i(m_lock_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .LOCK_O(LOCK_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .CTI_O(CTI_O), .BTE_O(BTE_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [3:0]  cyc;
    logic [3:0]  stb;
    logic [3:0]  lock;
    logic        ack;
    logic [3:0]  e_grant;
    logic        e_cyc;
    logic        e_stb;
    logic [3:0]  e_ack;
    logic [31:0] e_adr;
  } vec_t;

  vec_t tbl[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle's inputs just after the falling edge, then lets them settle.
  task automatic applyStimulus(input logic [3:0] cyc, input logic [3:0] stb,
                               input logic [3:0] lock, input logic ack,
                               input logic err, input logic rty, input bit rnd);
    @(negedge CLK_I);
    m_cyc_i  = cyc;
    m_stb_i  = stb;
    m_lock_i = lock;
    ACK_I    = ack;
    ERR_I    = err;
    RTY_I    = rty;
    if (rnd) begin
      for (int k = 0; k < NUM_M; k++) begin
        m_adr_i[k*AW +: AW] = $urandom;
        m_dat_i[k*DW +: DW] = $urandom;
        m_sel_i[k*4 +: 4]   = 4'($urandom);
        m_cti_i[k*3 +: 3]   = 3'($urandom);
        m_bte_i[k*2 +: 2]   = 2'($urandom);
        m_we_i[k]           = 1'($urandom);
      end
      DAT_I = $urandom;
    end
    #1;
  endtask

  task automatic modelReset();
    mdl_owner = -1;
    mdl_last  = NUM_M - 1;
    mdl_cnt   = 0;
  endtask

  // Compares every output with the model for the current cycle, then advances the model.
  task automatic modelCycle();
    int g;
    logic raw, resp, eto, estb, ecyc, ewe, elock;
    logic [3:0] eg, ea, ee, er, esel;
    logic [31:0] eadr, edat;
    logic [2:0] ecti;
    logic [1:0] ebte;
    g = mdl_owner;
    raw = 0; eto = 0; estb = 0; ecyc = 0; ewe = 0; elock = 0;
    eg = 0; ea = 0; ee = 0; er = 0; esel = 0; eadr = 0; edat = 0; ecti = 0; ebte = 0;
    resp = ACK_I | ERR_I | RTY_I;
    if (g >= 0) begin
      eg    = 4'(1 << g);
      ecyc  = m_cyc_i[g];
      raw   = m_cyc_i[g] & m_stb_i[g];
      eto   = raw && !resp && (mdl_cnt == TIMEOUT);
      estb  = raw && !eto;
      ea[g] = ACK_I & estb;
      ee[g] = (ERR_I & estb) | eto;
      er[g] = RTY_I & estb;
      eadr  = m_adr_i[g*AW +: AW];
      edat  = m_dat_i[g*DW +: DW];
      esel  = m_sel_i[g*4 +: 4];
      ecti  = m_cti_i[g*3 +: 3];
      ebte  = m_bte_i[g*2 +: 2];
      ewe   = m_we_i[g];
      elock = m_lock_i[g];
    end
    checkOutput("mdl grant", grant_o, eg);
    checkOutput("mdl cyc", CYC_O, ecyc);
    checkOutput("mdl stb", STB_O, estb);
    checkOutput("mdl ack", m_ack_o, ea);
    checkOutput("mdl err", m_err_o, ee);
    checkOutput("mdl rty", m_rty_o, er);
    checkOutput("mdl timeout", timeout_o, eto);
    checkOutput("mdl adr", ADR_O, eadr);
    checkOutput("mdl dat", DAT_O, edat);
    checkOutput("mdl sel", SEL_O, esel);
    checkOutput("mdl cti", CTI_O, ecti);
    checkOutput("mdl bte", BTE_O, ebte);
    checkOutput("mdl we", WE_O, ewe);
    checkOutput("mdl lock", LOCK_O, elock);
    checkOutput("mdl rdat", m_dat_o, DAT_I);
    mdl_cnt = (raw && !resp && !eto) ? mdl_cnt + 1 : 0;
    if (g < 0) begin
      for (int i = 1; i <= NUM_M; i++) begin
        if (mdl_owner < 0 && m_cyc_i[(mdl_last + i) % NUM_M])
          mdl_owner = (mdl_last + i) % NUM_M;
      end
    end else if (!m_cyc_i[g] && !m_lock_i[g]) begin
      mdl_last  = g;
      mdl_owner = -1;
    end
  endtask

  initial begin
    logic [3:0] rcyc, rlock, rstb;
    logic ra, re, rr;
    int sel;
    bit hang;

    tbl[0]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 32'hA000_0020};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 32'hA000_0020};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 32'hA000_0020};
    tbl[4]  = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[5]  = '{4'b1010, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 32'hA000_0010};
    tbl[6]  = '{4'b1010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 32'hA000_0010};
    tbl[7]  = '{4'b1000, 4'b1000, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 32'hA000_0010};
    tbl[8]  = '{4'b1000, 4'b1000, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 32'hA000_0010};
    tbl[9]  = '{4'b1000, 4'b1000, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 32'hA000_0010};
    tbl[10] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 32'hA000_0010};
    tbl[11] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0};
    tbl[12] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b0000, 32'hA000_0030};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b0000, 32'hA000_0030};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0};

    RST_I    = 1'b0;
    m_cyc_i  = '0; m_stb_i = '0; m_lock_i = '0; m_we_i = 4'b0101;
    m_adr_i  = {32'hA000_0030, 32'hA000_0020, 32'hA000_0010, 32'hA000_0000};
    m_dat_i  = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    m_sel_i  = 16'hF731;
    m_cti_i  = 12'o7210;
    m_bte_i  = 8'b11100100;
    DAT_I    = '0; ACK_I = 0; ERR_I = 0; RTY_I = 0;

    // Reset state
    repeat (2) @(posedge CLK_I);
    #1;
    checkOutput("rst grant", grant_o, 4'b0000);
    checkOutput("rst cyc", CYC_O, 1'b0);
    checkOutput("rst stb", STB_O, 1'b0);
    checkOutput("rst timeout", timeout_o, 1'b0);
    checkOutput("rst adr", ADR_O, 32'h0);
    checkOutput("rst ack", m_ack_o, 4'b0000);
    RST_I = 1'b1;
    modelReset();

    // Directed table: single request, then LOCK held across dropped CYC
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].cyc, tbl[i].stb, tbl[i].lock, tbl[i].ack, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("tbl%0d grant", i), grant_o, tbl[i].e_grant);
      checkOutput($sformatf("tbl%0d cyc", i), CYC_O, tbl[i].e_cyc);
      checkOutput($sformatf("tbl%0d stb", i), STB_O, tbl[i].e_stb);
      checkOutput($sformatf("tbl%0d ack", i), m_ack_o, tbl[i].e_ack);
      checkOutput($sformatf("tbl%0d adr", i), ADR_O, tbl[i].e_adr);
      modelCycle();
    end

    // Round robin: all request, each does one ACKed transfer then drops CYC
    for (int t = 0; t < 5; t++) begin
      logic [3:0] own;
      own = 4'(1 << (t % NUM_M));
      applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rr%0d idle grant", t), grant_o, 4'b0000);
      checkOutput($sformatf("rr%0d idle cyc", t), CYC_O, 1'b0);
      modelCycle();
      applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rr%0d grant", t), grant_o, own);
      checkOutput($sformatf("rr%0d ack", t), m_ack_o, own);
      modelCycle();
      applyStimulus(4'b1111 & ~own, 4'b1111 & ~own, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rr%0d hold grant", t), grant_o, own);
      checkOutput($sformatf("rr%0d drop cyc", t), CYC_O, 1'b0);
      modelCycle();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    modelCycle();

    // Watchdog expiry on a silent slave
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wd idle grant", grant_o, 4'b0000);
    modelCycle();
    for (int i = 1; i <= TIMEOUT + 2; i++) begin
      applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("wd%0d stb", i), STB_O, (i == TIMEOUT + 1) ? 1'b0 : 1'b1);
      checkOutput($sformatf("wd%0d err", i), m_err_o, (i == TIMEOUT + 1) ? 4'b0001 : 4'b0000);
      checkOutput($sformatf("wd%0d timeout", i), timeout_o, (i == TIMEOUT + 1) ? 1'b1 : 1'b0);
      modelCycle();
    end
    repeat (2) begin
      applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      modelCycle();
    end

    // Slave ACK in the would-be expiry cycle
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    modelCycle();
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      applyStimulus(4'b0001, 4'b0001, 4'b0000, (i == TIMEOUT + 1), 1'b0, 1'b0, 1'b0);
      if (i == TIMEOUT + 1) begin
        checkOutput("wdack ack", m_ack_o, 4'b0001);
        checkOutput("wdack err", m_err_o, 4'b0000);
        checkOutput("wdack timeout", timeout_o, 1'b0);
        checkOutput("wdack stb", STB_O, 1'b1);
      end
      modelCycle();
    end
    repeat (2) begin
      applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      modelCycle();
    end

    // Asynchronous reset in the middle of master 2's tenure
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    modelCycle();
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mrst pre grant", grant_o, 4'b0100);
    modelCycle();
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 RST_I = 1'b0;
    #1;
    checkOutput("mrst grant", grant_o, 4'b0000);
    checkOutput("mrst cyc", CYC_O, 1'b0);
    checkOutput("mrst stb", STB_O, 1'b0);
    checkOutput("mrst ack", m_ack_o, 4'b0000);
    checkOutput("mrst adr", ADR_O, 32'h0);
    @(posedge CLK_I);
    #1;
    checkOutput("mrst held grant", grant_o, 4'b0000);
    RST_I = 1'b1;
    modelReset();
    applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post rst idle", grant_o, 4'b0000);
    modelCycle();
    applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post rst grant", grant_o, 4'b0001);
    modelCycle();

    // Randomized traffic, alternating responsive and silent slave phases
    rcyc  = 4'b1111;
    rlock = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      hang = ((c / 64) % 2) == 1;
      for (int k = 0; k < NUM_M; k++) begin
        if ($urandom_range(0, 7) == 0) rcyc[k] = ~rcyc[k];
        if ($urandom_range(0, 9) == 0) rlock[k] = ~rlock[k];
      end
      rstb = hang ? rcyc : (rcyc & 4'($urandom));
      sel  = $urandom_range(0, 15);
      ra   = !hang && (sel <= 6);
      re   = !hang && (sel == 7);
      rr   = !hang && (sel == 8);
      applyStimulus(rcyc, rstb, rlock, ra, re, rr, 1'b1);
      modelCycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter sharing one Wishbone B4 slave port between NUM_M bus masters (e.g. several wishbone_master instances in the example system).
- Grants whole bus tenures (CYC-framed), honours LOCK, routes slave responses back to the owner only.
- Includes a response watchdog that terminates hung transfers with ERR.
- Sits between the master instances and the interconnect/slave.

Parameters:
- NUM_M, 4, number of requesting masters (2..8)
- WB_ADDR_W, 32, address width
- WB_DATA_W, 32, data width; SEL width = WB_DATA_W/8
- TIMEOUT, 256, watchdog limit in cycles (0 = watchdog disabled); counter width = $clog2(TIMEOUT+1)

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  async active-low reset
- m_cyc_i  in  NUM_M  per-master CYC
- m_stb_i  in  NUM_M  per-master STB
- m_we_i  in  NUM_M  per-master WE
- m_lock_i  in  NUM_M  per-master LOCK
- m_adr_i  in  NUM_M*WB_ADDR_W  flattened addresses, master k at [k*W +: W]
- m_dat_i  in  NUM_M*WB_DATA_W  flattened write data
- m_sel_i  in  NUM_M*WB_DATA_W/8  flattened SEL
- m_cti_i  in  NUM_M*3  flattened CTI
- m_bte_i  in  NUM_M*2  flattened BTE
- m_ack_o  out  NUM_M  per-master ACK
- m_err_o  out  NUM_M  per-master ERR
- m_rty_o  out  NUM_M  per-master RTY
- m_dat_o  out  WB_DATA_W  read data, broadcast to all masters
- CYC_O, STB_O, WE_O, LOCK_O  out  1 each  slave-side controls
- ADR_O  out  WB_ADDR_W  slave address
- DAT_O  out  WB_DATA_W  slave write data
- SEL_O  out  WB_DATA_W/8  slave byte select
- CTI_O  out  3  slave CTI
- BTE_O  out  2  slave BTE
- DAT_I  in  WB_DATA_W  slave read data
- ACK_I, ERR_I, RTY_I  in  1 each  slave responses
- grant_o  out  NUM_M  registered one-hot current owner (0 = none)
- timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset:
  - state IDLE, grant_o=0, rr pointer last=NUM_M-1 (master 0 highest priority first)
  - wd counter=0, timeout_o=0
  - all m_*_o and slave outputs 0
- FSM IDLE:
  - if any m_cyc_i, register grant for the first requester searching last+1, last+2, … modulo NUM_M
  - go to OWN next cycle; arbitration latency 1 cycle
  - CYC_O/STB_O held 0 while in IDLE
- FSM OWN (owner g):
  - slave outputs combinationally muxed from master g
  - CYC_O=m_cyc_i[g], STB_O=m_stb_i[g]&m_cyc_i[g]
  - m_ack_o[g]=ACK_I&STB_O, same gating for ERR/RTY
  - all other masters' responses 0
- Release, OWN -> IDLE:
  - when m_cyc_i[g]=0 and m_lock_i[g]=0
  - on release, last<=g, grant_o<=0
  - at least one idle cycle (CYC_O=0) between tenures, even with other requests pending
- LOCK: while m_lock_i[g]=1 the grant is held even if CYC drops between cycles; no other master is granted.
- Non-owner CYC/STB changes have no effect mid-tenure.
- Watchdog (TIMEOUT>0):
  - count increments each cycle STB_O=1 with ACK_I|ERR_I|RTY_I=0; cleared on any response or STB_O=0
  - when count reaches TIMEOUT: m_err_o[g]=1 and timeout_o=1 for one cycle, STB_O forced 0 that cycle, counter cleared
  - simultaneous slave ACK in the expiry cycle: ACK wins, no timeout
- Slave ERR/RTY passed through unchanged; arbiter does not retry.
- m_dat_o = DAT_I always.
- Owner drops CYC mid-burst (CTI≠111): treated as release, no error generated.
- Reset mid-tenure: immediate return to reset values; pointer back to NUM_M-1.

Test Plan:
- Single request: m_cyc_i=4'b0100 at cycle 0 -> grant_o=4'b0100 at cycle 1, ADR_O=master-2 address, slave ACK routed only to m_ack_o[2].
- All four request continuously, each doing one ACKed transfer then dropping CYC -> grant order 0,1,2,3,0 with one idle CYC_O=0 cycle between tenures.
- Master 1 raises LOCK, drops CYC for 3 cycles while master 3 requests -> grant_o stays 4'b0010 until LOCK falls, then 4'b1000 after one idle cycle.
- TIMEOUT=8, slave never responds -> after 8 STB cycles m_err_o[owner]=1 and timeout_o=1 for 1 cycle, STB_O=0 in that cycle.
- Slave ACK in the same cycle the counter hits TIMEOUT -> m_ack_o asserted, m_err_o=0, timeout_o=0.
- Assert RST_I=0 mid-burst on master 2 -> all outputs 0 asynchronously; after release with all requesting, master 0 is granted first.
